id_ex_stage: RTL and testbench

- Registered decode-to-execute stage sitting directly upstream of the 32-bit ALU.
- Takes a fetched/decoded instruction plus register-file read data and produces, one cycle later, the ALU operands (A, B) and the 4-bit ALU op code.
- Also registers the control bits needed by the memory and writeback stages.
- Supports pipeline stall (hold) and flush (bubble).

---
 rtl/mips_pkg.sv | 69 ++++++
 rtl/alu_ctrl_dec.sv | 111 +++++++++++
 rtl/id_ex_stage.sv | 167 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared decode types for the ID/EX slice: ALU op codes, MIPS opcode and
// funct values, the control-bit bundle and the operand-B source select.
package mips_pkg;

  // ALU operation codes understood by the downstream 32-bit ALU.
  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SLL = 4'd3,
    ALU_SRL = 4'd4,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12
  } alu_op_t;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0]).
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Control bits carried to the memory and writeback stages.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE    = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0, illegal: 1'b0};
  localparam ctrl_t CTRL_ILLEGAL = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0, illegal: 1'b1};
  localparam ctrl_t CTRL_WRITE   = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0, illegal: 1'b0};
  localparam ctrl_t CTRL_LOAD    = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0, branch: 1'b0, illegal: 1'b0};
  localparam ctrl_t CTRL_STORE   = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b1, branch: 1'b0, illegal: 1'b0};
  localparam ctrl_t CTRL_BRANCH  = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, branch: 1'b1, illegal: 1'b0};

  // Where operand B comes from.
  typedef enum logic [1:0] {
    B_RT    = 2'd0,
    B_SEXT  = 2'd1,
    B_ZEXT  = 2'd2,
    B_SHAMT = 2'd3
  } bsel_t;

  // Sign-extend a 16-bit immediate to 32 bits.
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Purely combinational instruction decoder: opcode/funct -> ALU op, control
// bits, operand-B source, operand-A source (rt for shifts) and destination
// field select (rd for R-type, rt otherwise).
module alu_ctrl_dec
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_t    alu_op,
  output ctrl_t      ctrl,
  output bsel_t      b_sel,
  output logic       a_from_rt,
  output logic       dst_is_rd
);

  // Decode table; anything not matched stays illegal with alu_op = AND.
  always_comb begin
    alu_op    = ALU_AND;
    ctrl      = CTRL_ILLEGAL;
    b_sel     = B_RT;
    a_from_rt = 1'b0;
    dst_is_rd = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dst_is_rd = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: begin
            alu_op = ALU_ADD;
            ctrl   = CTRL_WRITE;
          end
          FN_SUB, FN_SUBU: begin
            alu_op = ALU_SUB;
            ctrl   = CTRL_WRITE;
          end
          FN_AND: begin
            alu_op = ALU_AND;
            ctrl   = CTRL_WRITE;
          end
          FN_OR: begin
            alu_op = ALU_OR;
            ctrl   = CTRL_WRITE;
          end
          FN_NOR: begin
            alu_op = ALU_NOR;
            ctrl   = CTRL_WRITE;
          end
          FN_SLT: begin
            alu_op = ALU_SLT;
            ctrl   = CTRL_WRITE;
          end
          FN_SLL: begin
            alu_op    = ALU_SLL;
            ctrl      = CTRL_WRITE;
            a_from_rt = 1'b1;
            b_sel     = B_SHAMT;
          end
          FN_SRL: begin
            alu_op    = ALU_SRL;
            ctrl      = CTRL_WRITE;
            a_from_rt = 1'b1;
            b_sel     = B_SHAMT;
          end
          default: begin
            alu_op = ALU_AND;
            ctrl   = CTRL_ILLEGAL;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        alu_op = ALU_ADD;
        ctrl   = CTRL_WRITE;
        b_sel  = B_SEXT;
      end
      OP_SLTI: begin
        alu_op = ALU_SLT;
        ctrl   = CTRL_WRITE;
        b_sel  = B_SEXT;
      end
      OP_ANDI: begin
        alu_op = ALU_AND;
        ctrl   = CTRL_WRITE;
        b_sel  = B_ZEXT;
      end
      OP_ORI: begin
        alu_op = ALU_OR;
        ctrl   = CTRL_WRITE;
        b_sel  = B_ZEXT;
      end
      OP_LW: begin
        alu_op = ALU_ADD;
        ctrl   = CTRL_LOAD;
        b_sel  = B_SEXT;
      end
      OP_SW: begin
        alu_op = ALU_ADD;
        ctrl   = CTRL_STORE;
        b_sel  = B_SEXT;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        ctrl   = CTRL_BRANCH;
        b_sel  = B_RT;
      end
      default: begin
        alu_op = ALU_AND;
        ctrl   = CTRL_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Registered decode-to-execute pipeline stage feeding the 32-bit ALU.
// Produces ALU operands/op code and MEM/WB control bits one cycle after the
// instruction is presented; supports stall (hold) and flush (bubble).
// Optional build macro ID_EX_FORWARD_EN adds fwd_valid/fwd_addr/fwd_data
// ports that bypass writeback data onto rs/rt before registering.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            stall,
  input  logic            flush,
`ifdef ID_EX_FORWARD_EN
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_addr,
  input  logic [XLEN-1:0] fwd_data,
`endif
  output logic            out_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] rt_store,
  output logic [4:0]      wr_addr,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic [XLEN-1:0] branch_target,
  output logic            illegal
);

  // Instruction fields.
  logic [5:0]  opcode;
  logic [4:0]  rt_field;
  logic [4:0]  rd_field;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign opcode   = instr[31:26];
  assign rt_field = instr[20:16];
  assign rd_field = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];

  // Register operands after optional bypass.
  logic [XLEN-1:0] rs_eff;
  logic [XLEN-1:0] rt_eff;

`ifdef ID_EX_FORWARD_EN
  logic [4:0] rs_field;
  assign rs_field = instr[25:21];
  // Register 0 is never forwarded: it always reads as whatever the file gives.
  assign rs_eff = (fwd_valid && (fwd_addr != 5'd0) && (fwd_addr == rs_field)) ? fwd_data : rs_data;
  assign rt_eff = (fwd_valid && (fwd_addr != 5'd0) && (fwd_addr == rt_field)) ? fwd_data : rt_data;
`else
  // The rs field only matters for bypass matching.
  logic unused_rs_field;
  assign unused_rs_field = ^instr[25:21];
  assign rs_eff = rs_data;
  assign rt_eff = rt_data;
`endif

  // Decoder outputs.
  alu_op_t dec_op;
  ctrl_t   dec_ctrl;
  bsel_t   dec_bsel;
  logic    dec_a_rt;
  logic    dec_dst_rd;

  alu_ctrl_dec u_dec (
    .opcode    (opcode),
    .funct     (funct),
    .alu_op    (dec_op),
    .ctrl      (dec_ctrl),
    .b_sel     (dec_bsel),
    .a_from_rt (dec_a_rt),
    .dst_is_rd (dec_dst_rd)
  );

  // Values to be captured on a load edge.
  logic [XLEN-1:0] a_next;
  logic [XLEN-1:0] b_next;
  logic [4:0]      wr_next;
  ctrl_t           ctrl_next;
  logic [XLEN-1:0] bt_next;

  // Operand muxing, destination select and $0 write suppression.
  always_comb begin
    a_next    = dec_a_rt ? rt_eff : rs_eff;
    b_next    = rt_eff;
    wr_next   = dec_dst_rd ? rd_field : rt_field;
    ctrl_next = dec_ctrl;
    case (dec_bsel)
      B_RT:    b_next = rt_eff;
      B_SEXT:  b_next = sext16(imm);
      B_ZEXT:  b_next = {16'h0000, imm};
      B_SHAMT: b_next = {27'd0, shamt};
      default: b_next = rt_eff;
    endcase
    if (wr_next == 5'd0) begin
      ctrl_next.reg_write = 1'b0;
    end
    // Wraps modulo 2^32 by construction of the 32-bit add.
    bt_next = pc_plus4 + (sext16(imm) << 2);
  end

  // Pipeline registers.
  logic            valid_reg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  alu_op_t         op_reg;
  logic [XLEN-1:0] rt_store_reg;
  logic [4:0]      wr_reg;
  ctrl_t           ctrl_reg;
  logic [XLEN-1:0] bt_reg;

  // Stage register update: reset > flush > stall > load (bubble if !in_valid).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= ALU_AND;
      rt_store_reg <= '0;
      wr_reg       <= 5'd0;
      ctrl_reg     <= CTRL_NONE;
      bt_reg       <= RESET_PC;
    end else if (flush) begin
      // Squash only the control bits; the data fields keep their old value.
      valid_reg <= 1'b0;
      ctrl_reg  <= CTRL_NONE;
    end else if (!stall) begin
      valid_reg    <= in_valid;
      ctrl_reg     <= in_valid ? ctrl_next : CTRL_NONE;
      a_reg        <= a_next;
      b_reg        <= b_next;
      op_reg       <= dec_op;
      rt_store_reg <= rt_eff;
      wr_reg       <= wr_next;
      bt_reg       <= bt_next;
    end
  end

  assign out_valid     = valid_reg;
  assign alu_a         = a_reg;
  assign alu_b         = b_reg;
  assign alu_op        = op_reg;
  assign rt_store      = rt_store_reg;
  assign wr_addr       = wr_reg;
  assign reg_write     = ctrl_reg.reg_write;
  assign mem_read      = ctrl_reg.mem_read;
  assign mem_write     = ctrl_reg.mem_write;
  assign branch        = ctrl_reg.branch;
  assign illegal       = ctrl_reg.illegal;
  assign branch_target = bt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps followed by random
// traffic, all compared against a behavioural reference model.
module tb_id_ex_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        flush;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] rt_store;
  logic [4:0]  wr_addr;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic [31:0] branch_target;
  logic        illegal;

  id_ex_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .instr         (instr),
    .pc_plus4      (pc_plus4),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .stall         (stall),
    .flush         (flush),
`ifdef ID_EX_FORWARD_EN
    .fwd_valid     (fwd_valid),
    .fwd_addr      (fwd_addr),
    .fwd_data      (fwd_data),
`endif
    .out_valid     (out_valid),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .rt_store      (rt_store),
    .wr_addr       (wr_addr),
    .reg_write     (reg_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .branch        (branch),
    .branch_target (branch_target),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected stage contents.
  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] rts;
    logic [4:0]  wr;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        ill;
    logic [31:0] bt;
  } exp_t;

  exp_t m;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  // Reference decode, written from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] iw, input logic [31:0] rs_v,
                                      input logic [31:0] rt_v, input logic [31:0] pc);
    exp_t e;
    int unsigned opc;
    int unsigned fn;
    logic [31:0] uimm;
    logic [31:0] simm;
    opc  = iw >> 26;
    fn   = iw & 32'h3F;
    uimm = iw & 32'hFFFF;
    simm = (uimm >= 32'h8000) ? (uimm - 32'h10000) : uimm;
    e = '0;
    e.valid = 1'b1;
    e.rts   = rt_v;
    e.bt    = pc + simm * 4;
    e.ill   = 1'b1;
    e.op    = 4'd0;
    if (opc == 0) begin
      e.wr = (iw >> 11) & 32'h1F;
      e.a  = rs_v;
      e.b  = rt_v;
      e.ill = 1'b0;
      e.rw  = 1'b1;
      case (fn)
        'h20, 'h21: e.op = 4'd2;
        'h22, 'h23: e.op = 4'd6;
        'h24:       e.op = 4'd0;
        'h25:       e.op = 4'd1;
        'h27:       e.op = 4'd12;
        'h2A:       e.op = 4'd7;
        'h00: begin e.op = 4'd3; e.a = rt_v; e.b = (iw >> 6) & 32'h1F; end
        'h02: begin e.op = 4'd4; e.a = rt_v; e.b = (iw >> 6) & 32'h1F; end
        default: begin e.ill = 1'b1; e.rw = 1'b0; e.op = 4'd0; end
      endcase
    end else begin
      e.wr = (iw >> 16) & 32'h1F;
      e.a  = rs_v;
      e.ill = 1'b0;
      case (opc)
        'h08, 'h09: begin e.op = 4'd2; e.b = simm; e.rw = 1'b1; end
        'h0A:       begin e.op = 4'd7; e.b = simm; e.rw = 1'b1; end
        'h0C:       begin e.op = 4'd0; e.b = uimm; e.rw = 1'b1; end
        'h0D:       begin e.op = 4'd1; e.b = uimm; e.rw = 1'b1; end
        'h23:       begin e.op = 4'd2; e.b = simm; e.rw = 1'b1; e.mr = 1'b1; end
        'h2B:       begin e.op = 4'd2; e.b = simm; e.mw = 1'b1; end
        'h04:       begin e.op = 4'd6; e.b = rt_v; e.br = 1'b1; end
        default:    begin e.ill = 1'b1; e.op = 4'd0; end
      endcase
    end
    if (e.wr == 0) e.rw = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the current inputs, then compare.
  task automatic step(input string name, input bit full);
    logic [31:0] rs_v;
    logic [31:0] rt_v;
    exp_t d;
    @(posedge clk);
    rs_v = rs_data;
    rt_v = rt_data;
`ifdef ID_EX_FORWARD_EN
    if (fwd_valid && fwd_addr != 0 && fwd_addr == instr[25:21]) rs_v = fwd_data;
    if (fwd_valid && fwd_addr != 0 && fwd_addr == instr[20:16]) rt_v = fwd_data;
`endif
    if (!rst_n) begin
      m = '0;
      m.bt = RESET_PC;
    end else if (flush) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.br = 0; m.ill = 0;
    end else if (!stall) begin
      d = ref_decode(instr, rs_v, rt_v, pc_plus4);
      if (!in_valid) begin
        d.valid = 0; d.rw = 0; d.mr = 0; d.mw = 0; d.br = 0; d.ill = 0;
      end
      m = d;
    end
    #1;
    chk({name, ".out_valid"}, 32'(out_valid), 32'(m.valid));
    chk({name, ".reg_write"}, 32'(reg_write), 32'(m.rw));
    chk({name, ".mem_read"},  32'(mem_read),  32'(m.mr));
    chk({name, ".mem_write"}, 32'(mem_write), 32'(m.mw));
    chk({name, ".branch"},    32'(branch),    32'(m.br));
    chk({name, ".illegal"},   32'(illegal),   32'(m.ill));
    if (full || m.valid) begin
      chk({name, ".alu_op"},        32'(alu_op), 32'(m.op));
      chk({name, ".rt_store"},      rt_store,      m.rts);
      chk({name, ".branch_target"}, branch_target, m.bt);
    end
    if (full || (m.valid && !m.ill)) begin
      chk({name, ".alu_a"},   alu_a,            m.a);
      chk({name, ".alu_b"},   alu_b,            m.b);
      chk({name, ".wr_addr"}, 32'(wr_addr),     32'(m.wr));
    end
    n_txn++;
    $display("txn %0d %s instr=%h stall=%0b flush=%0b -> valid=%0b op=%0d a=%h b=%h wr=%0d rw=%0b",
             n_txn, name, instr, stall, flush, out_valid, alu_op, alu_a, alu_b, wr_addr, reg_write);
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
    return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (32'(imm) & 32'hFFFF);
  endfunction

  initial begin
    int ops[9];
    int fns[10];
    ops = '{'h08, 'h09, 'h0A, 'h0C, 'h0D, 'h23, 'h2B, 'h04, 'h3F};
    fns = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h27, 'h2A, 'h00, 'h02};
    m = '0;
    rst_n = 0; in_valid = 0; instr = 0; pc_plus4 = 0; rs_data = 0; rt_data = 0;
    stall = 0; flush = 0; fwd_valid = 0; fwd_addr = 0; fwd_data = 0;

    // Reset for two cycles.
    step("reset0", 1);
    step("reset1", 1);
    chk("reset.branch_target", branch_target, RESET_PC);
    chk("reset.alu_a", alu_a, 32'd0);

    // add $3,$1,$2
    rst_n = 1; in_valid = 1; rs_data = 5; rt_data = 7;
    instr = rtype(1, 2, 3, 0, 'h20);
    step("add", 0);
    chk("add.alu_op", 32'(alu_op), 32'd2);
    chk("add.alu_a", alu_a, 32'd5);
    chk("add.alu_b", alu_b, 32'd7);
    chk("add.wr_addr", 32'(wr_addr), 32'd3);

    // sll $4,$2,3
    rt_data = 1; instr = rtype(0, 2, 4, 3, 'h00);
    step("sll", 0);
    chk("sll.alu_b", alu_b, 32'd3);

    // ori $5,$1,0x8000
    instr = itype('h0D, 1, 5, 'h8000);
    step("ori", 0);
    chk("ori.alu_b", alu_b, 32'h0000_8000);

    // lw $6,-4($1)
    instr = itype('h23, 1, 6, 'hFFFC);
    step("lw", 0);
    chk("lw.alu_b", alu_b, 32'hFFFF_FFFC);

    // beq $1,$2,-1 at pc+4 = 0x100
    pc_plus4 = 32'h100; instr = itype('h04, 1, 2, 'hFFFF);
    step("beq", 0);
    chk("beq.branch_target", branch_target, 32'h0000_00FC);

    // Stall for 3 cycles while the input changes.
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      instr = rtype(i + 1, i + 2, i + 3, 0, 'h22);
      rs_data = $urandom; rt_data = $urandom; pc_plus4 = $urandom;
      step("stall", 0);
      chk("stall.branch_target", branch_target, 32'h0000_00FC);
    end

    // Stall and flush together.
    flush = 1;
    step("stall_flush", 0);
    stall = 0; flush = 0;

    // Unsupported opcode.
    instr = itype('h3F, 1, 7, 'h1234);
    step("illegal_op", 0);

    // R-type writing $0.
    instr = rtype(1, 2, 0, 0, 'h20);
    step("rd_zero", 0);

`ifdef ID_EX_FORWARD_EN
    rs_data = 5; rt_data = 7; instr = rtype(1, 2, 3, 0, 'h20);
    fwd_valid = 1; fwd_addr = 1; fwd_data = 32'hAA;
    step("fwd_hit", 0);
    chk("fwd_hit.alu_a", alu_a, 32'hAA);
    fwd_addr = 0;
    step("fwd_zero", 0);
    chk("fwd_zero.alu_a", alu_a, 32'd5);
    fwd_valid = 0;
`endif

    // Reset asserted while stalled.
    instr = rtype(1, 2, 3, 0, 'h25);
    step("pre_rst", 0);
    stall = 1; rst_n = 0;
    step("rst_in_stall", 1);
    stall = 0; rst_n = 1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int rs_f;
      int rt_f;
      rs_f = $urandom_range(0, 7);
      rt_f = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0)
        instr = $urandom;
      else if ($urandom_range(0, 1) == 0)
        instr = rtype(rs_f, rt_f, $urandom_range(0, 7), $urandom_range(0, 31),
                      fns[$urandom_range(0, 9)]);
      else
        instr = itype(ops[$urandom_range(0, 8)], rs_f, rt_f, $urandom);
      rs_data  = $urandom;
      rt_data  = $urandom;
      pc_plus4 = $urandom;
      in_valid = ($urandom_range(0, 7) != 0);
      stall    = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      rst_n    = ($urandom_range(0, 63) != 0);
      fwd_valid = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0: fwd_addr = instr[25:21];
        1: fwd_addr = instr[20:16];
        default: fwd_addr = 5'($urandom);
      endcase
      fwd_data = $urandom;
      step("rand", !rst_n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
